// File: rtl/qcs_gpio_rtl_pkg.sv
// Shared constants and types for the GPIO input debounce block.
// Per-bit status is carried between the bit slices and the top as a struct.
package qcs_gpio_rtl_pkg;

    localparam int QCS_GPIO_MAX_WIDTH = 32;
    localparam int QCS_GPIO_DEB_CNT_W = 8;

    typedef struct packed {
        logic val;
        logic rise;
        logic fall;
    } qcs_gpio_bit_t;

endpackage

// File: rtl/qcs_gpio_in_bit.sv
// One GPIO input slice: synchroniser, debounce counter,
// debounced value flop and registered edge pulses.
module qcs_gpio_in_bit
    import qcs_gpio_rtl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = QCS_GPIO_DEB_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pin,
    input  logic [DEB_CNT_W-1:0] deb_limit,
    output qcs_gpio_bit_t        st
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_CNT_W-1:0]   cnt_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    // >= so a lowered limit takes effect on the next differing cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            st    <= '0;
        end else begin
            st.rise <= 1'b0;
            st.fall <= 1'b0;
            if (s == st.val) begin
                cnt_q <= '0;
            end else if (cnt_q >= deb_limit) begin
                cnt_q   <= '0;
                st.val  <= s;
                st.rise <= s;
                st.fall <= ~s;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/qcs_gpio_in_deb.sv
// GPIO input block: per-bit synchronise and debounce slices,
// sticky maskable edge status and a registered combined irq.
module qcs_gpio_in_deb
    import qcs_gpio_rtl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT_W   = QCS_GPIO_DEB_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gpio_in,
    input  logic [DEB_CNT_W-1:0] deb_limit,
    input  logic [WIDTH-1:0]     rise_en,
    input  logic [WIDTH-1:0]     fall_en,
    input  logic [WIDTH-1:0]     irq_clr,
    output logic [WIDTH-1:0]     gpio_val,
    output logic [WIDTH-1:0]     rise_pulse,
    output logic [WIDTH-1:0]     fall_pulse,
    output logic [WIDTH-1:0]     irq_status,
    output logic                 irq
);

    if (WIDTH < 1 || WIDTH > QCS_GPIO_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "qcs_gpio_in_deb: WIDTH out of range");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "qcs_gpio_in_deb: SYNC_STAGES must be >= 2");
    end

    qcs_gpio_bit_t bit_st [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        qcs_gpio_in_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CNT_W   (DEB_CNT_W)
        ) u_bit (
            .clk       (clk),
            .rst       (rst),
            .pin       (gpio_in[i]),
            .deb_limit (deb_limit),
            .st        (bit_st[i])
        );

        assign gpio_val[i]   = bit_st[i].val;
        assign rise_pulse[i] = bit_st[i].rise;
        assign fall_pulse[i] = bit_st[i].fall;
    end

    // set terms are OR-ed after the clear so a same-cycle set wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clr)
                        | (rise_pulse & rise_en)
                        | (fall_pulse & fall_en);
            irq        <= |irq_status;
        end
    end

endmodule

// File: tb/tb_qcs_gpio_in_deb.sv
// Scoreboard bench for qcs_gpio_in_deb: directed plan plus random
// pin traffic checked against a sliding-window reference model.
module tb_qcs_gpio_in_deb;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gpio_in = '0;
    logic [7:0]   deb_limit = 8'd3;
    logic [W-1:0] rise_en = '0;
    logic [W-1:0] fall_en = '0;
    logic [W-1:0] irq_clr = '0;
    logic [W-1:0] gpio_val;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] irq_status;
    logic         irq;

    always #5 clk = ~clk;

    qcs_gpio_in_deb #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .DEB_CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_in    (gpio_in),
        .deb_limit  (deb_limit),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .irq_clr    (irq_clr),
        .gpio_val   (gpio_val),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .irq_status (irq_status),
        .irq        (irq)
    );

    typedef struct packed {
        logic [W-1:0] val;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] st;
        logic         irq;
    } exp_t;

    exp_t         expq[$];
    logic [W-1:0] pq[$];
    logic [W-1:0] sh[$];
    logic [W-1:0] m_val;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic [W-1:0] m_st;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h t=%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        for (int k = 0; k < S; k++) pq.push_back('0);
        sh.delete();
        m_val  = '0;
        m_rise = '0;
        m_fall = '0;
        m_st   = '0;
    endtask

    // A bit flips once the last deb_limit+1 synchronised
    // samples all disagree with its debounced value.
    task automatic model_edge();
        exp_t         e;
        logic [W-1:0] s;
        logic [W-1:0] nv;
        logic [W-1:0] nr;
        logic [W-1:0] nf;
        logic         diff;
        if (rst) begin
            model_reset();
            e = '0;
            expq.push_back(e);
            return;
        end
        s = pq.pop_front();
        pq.push_back(gpio_in);
        sh.push_back(s);
        while (sh.size() > int'(deb_limit) + 1) sh.delete(0);
        nv = m_val;
        nr = '0;
        nf = '0;
        for (int i = 0; i < W; i++) begin
            diff = (sh.size() == int'(deb_limit) + 1);
            foreach (sh[k])
                if (sh[k][i] == m_val[i]) diff = 1'b0;
            if (diff) begin
                nv[i] = s[i];
                nr[i] = s[i];
                nf[i] = ~s[i];
            end
        end
        e.st   = (m_st & ~irq_clr) | (m_rise & rise_en)
               | (m_fall & fall_en);
        e.irq  = |m_st;
        e.val  = nv;
        e.rise = nr;
        e.fall = nf;
        m_val  = nv;
        m_rise = nr;
        m_fall = nf;
        m_st   = e.st;
        expq.push_back(e);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got 0 entries required >=1");
            end else begin
                e = expq.pop_front();
                chk("sb_gpio_val", 32'(gpio_val), 32'(e.val));
                chk("sb_rise", 32'(rise_pulse), 32'(e.rise));
                chk("sb_fall", 32'(fall_pulse), 32'(e.fall));
                chk("sb_status", 32'(irq_status), 32'(e.st));
                chk("sb_irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    initial begin
        model_reset();
        cyc(3);
        chk("rst_val", 32'(gpio_val), 0);
        chk("rst_status", 32'(irq_status), 0);
        rst = 1'b0;
        cyc(3);

        // single rise, limit 3: visible 6 edges later
        gpio_in = 8'h01;
        cyc(5);
        chk("t1_early", 32'(gpio_val), 0);
        cyc(1);
        chk("t1_val", 32'(gpio_val), 32'h01);
        chk("t1_rise", 32'(rise_pulse), 32'h01);
        cyc(1);
        chk("t1_rise_end", 32'(rise_pulse), 0);
        gpio_in = 8'h00;
        cyc(10);

        // 3-cycle glitch ignored, 4-cycle pulse accepted
        gpio_in = 8'h04;
        cyc(3);
        gpio_in = 8'h00;
        cyc(8);
        chk("t2_glitch", 32'(gpio_val), 0);
        gpio_in = 8'h04;
        cyc(4);
        gpio_in = 8'h00;
        cyc(2);
        chk("t2_val", 32'(gpio_val), 32'h04);
        chk("t2_rise", 32'(rise_pulse), 32'h04);
        cyc(10);

        // status and irq on rise only
        rise_en = 8'h01;
        gpio_in = 8'h01;
        cyc(7);
        chk("t3_status", 32'(irq_status), 32'h01);
        chk("t3_irq_lag", 32'(irq), 0);
        cyc(1);
        chk("t3_irq", 32'(irq), 1);
        gpio_in = 8'h00;
        cyc(8);
        chk("t3_fall_val", 32'(gpio_val), 0);
        chk("t3_fall_status", 32'(irq_status), 32'h01);
        irq_clr = 8'h01;
        cyc(1);
        irq_clr = 8'h00;
        chk("t3_clr", 32'(irq_status), 0);
        cyc(1);
        chk("t3_irq_clr", 32'(irq), 0);

        // clear in the same cycle as the setting pulse
        gpio_in = 8'h01;
        cyc(6);
        chk("t4_pulse", 32'(rise_pulse), 32'h01);
        irq_clr = 8'h01;
        cyc(1);
        irq_clr = 8'h00;
        chk("t4_set_wins", 32'(irq_status), 32'h01);
        cyc(2);

        // limit 0: all bits together after 3 edges
        rst = 1'b1;
        gpio_in = 8'h00;
        deb_limit = 8'd0;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        gpio_in = 8'hFF;
        cyc(2);
        chk("t5_early", 32'(gpio_val), 0);
        cyc(1);
        chk("t5_val", 32'(gpio_val), 32'hFF);
        chk("t5_rise", 32'(rise_pulse), 32'hFF);

        // reset mid-count on bit 5
        deb_limit = 8'd3;
        gpio_in = 8'hDF;
        cyc(4);
        rst = 1'b1;
        #1;
        chk("t6_rst_val", 32'(gpio_val), 0);
        chk("t6_rst_pulse", 32'(rise_pulse | fall_pulse), 0);
        chk("t6_rst_irq", 32'({irq_status, irq}), 0);
        gpio_in = 8'h20;
        cyc(2);
        rst = 1'b0;
        cyc(5);
        chk("t6_early", 32'(gpio_val), 0);
        cyc(1);
        chk("t6_val", 32'(gpio_val), 32'h20);
        chk("t6_rise", 32'(rise_pulse), 32'h20);

        // random traffic, limit fixed between resets
        for (int r = 0; r < 6; r++) begin
            rst = 1'b1;
            deb_limit = 8'($urandom_range(0, 5));
            rise_en = W'($urandom);
            fall_en = W'($urandom);
            gpio_in = W'($urandom);
            cyc(2);
            rst = 1'b0;
            for (int c = 0; c < 400; c++) begin
                for (int i = 0; i < W; i++)
                    if ($urandom_range(0, 5) == 0)
                        gpio_in[i] = ~gpio_in[i];
                irq_clr = ($urandom_range(0, 3) == 0) ?
                          W'($urandom) : '0;
                if ($urandom_range(0, 49) == 0) begin
                    rise_en = W'($urandom);
                    fall_en = W'($urandom);
                end
                rst = ($urandom_range(0, 199) == 0);
                cyc(1);
            end
        end
        rst = 1'b0;
        irq_clr = '0;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qcs_gpio_in_deb.md
Name: qcs_gpio_in_deb

Overview:
- Chip-side consumer of the GPIO pins driven by the GPIO UVC driver.
- Synchronises each asynchronous gpio input bit into the clk domain and debounces it with a programmable stable-time.
- Produces single-cycle rise/fall pulses per bit and maintains sticky, maskable interrupt status with a combined irq.
- Sits between the pad ring and the GPIO register block.

Parameters:
- WIDTH, 8, number of GPIO bits; must be 1..QCS_GPIO_MAX_WIDTH (fatal at elaboration otherwise).
- SYNC_STAGES, 2, synchroniser depth; must be >= 2.
- DEB_CNT_W, 8, width of the debounce counter and of deb_limit.

Ports:
- clk  input  1  block clock.
- rst  input  1  asynchronous, active-high reset.
- gpio_in  input  WIDTH  raw pin values, asynchronous to clk.
- deb_limit  input  DEB_CNT_W  debounce threshold, quasi-static config shared by all bits.
- rise_en  input  WIDTH  per-bit enable: rising edge sets status.
- fall_en  input  WIDTH  per-bit enable: falling edge sets status.
- irq_clr  input  WIDTH  write-1-to-clear pulse for irq_status.
- gpio_val  output  WIDTH  debounced pin value.
- rise_pulse  output  WIDTH  1-cycle pulse on debounced 0->1.
- fall_pulse  output  WIDTH  1-cycle pulse on debounced 1->0.
- irq_status  output  WIDTH  sticky edge status.
- irq  output  1  OR-reduction of irq_status.

Behaviour:
- Reset (async assert, sync release):
  - synchroniser flops, gpio_val, counters, rise_pulse, fall_pulse, irq_status and irq all = 0.
  - A mid-operation reset discards any count in progress and any pending pulse.
  - No edge pulse is generated on the first post-reset update.
- Synchroniser: s = gpio_in delayed by SYNC_STAGES flops, per bit. No combinational path from gpio_in to any output.
- Debounce, per bit i, each cycle:
  - If s[i] == gpio_val[i]: cnt[i] <= 0.
  - Else if cnt[i] >= deb_limit: gpio_val[i] <= s[i], cnt[i] <= 0, and the matching pulse fires.
  - Else: cnt[i] <= cnt[i] + 1.
  - The >= compare covers deb_limit being lowered mid-count: the update happens on the next differing cycle.
  - cnt never exceeds deb_limit; no wrap.
- Latency: a clean pin change at cycle n shows on gpio_val and its pulse at cycle n + SYNC_STAGES + deb_limit + 1.
  - deb_limit = 0 gives minimum latency SYNC_STAGES + 1.
- Glitch rejection: any excursion of s lasting <= deb_limit cycles is ignored, and the counter restarts from 0 when it ends.
- Pulses:
  - rise_pulse[i] = 1 for exactly the cycle after gpio_val[i] goes 0->1 is registered (registered outputs, aligned with the new gpio_val).
  - fall_pulse[i] likewise for 1->0.
  - Rise and fall of the same bit are never asserted together.
- Status: irq_status[i] <= (irq_status[i] & ~irq_clr[i]) | (rise_pulse[i] & rise_en[i]) | (fall_pulse[i] & fall_en[i]).
  - Set and clear in the same cycle: set wins.
  - Clearing a 0 bit has no effect.
  - Enables are sampled in the pulse cycle only; enabling later does not capture a past edge.
- irq: registered, = |irq_status, one cycle after the status update.
- All bits are independent; multiple bits may pulse in the same cycle.

Decomposition:
- Shared package qcs_gpio_rtl_pkg holds:
  - constant QCS_GPIO_MAX_WIDTH = 32 (matches the UVC limit);
  - default DEB_CNT_W;
  - typedef of the per-bit status struct {val, rise, fall}.
- One sub-module, qcs_gpio_in_bit, is instantiated WIDTH times by generate. It contains the synchroniser, debounce counter, gpio_val flop and pulse logic.
- The top holds irq_status, the clear/set logic and the irq reduction.

Test Plan:
- Reset, then WIDTH=8, SYNC_STAGES=2, deb_limit=3; drive bit0 0->1 at cycle 10 → gpio_val[0]=1 and rise_pulse[0]=1 at cycle 16 only; all other outputs unchanged.
- Same config, 3-cycle glitch on bit2 (0->1->0) → no change on gpio_val[2] and no pulse. Then a 4-cycle high → gpio_val[2]=1 with rise_pulse[2].
- rise_en=0x01, fall_en=0x00; bit0 rises then falls → irq_status=0x01 after the rise and irq=1 one cycle later. The fall adds nothing. irq_clr=0x01 → status=0, irq=0 the next cycle.
- irq_clr[0] asserted in the same cycle rise_pulse[0] sets status → irq_status[0] stays 1.
- deb_limit=0, toggle bits 0..7 simultaneously → all 8 gpio_val bits update 3 cycles later with 8 concurrent pulses.
- Assert rst while bit5's count = 2 of 3 → all outputs 0 immediately. After release with pin held high, gpio_val[5]=1 after the full 6-cycle latency; rise_pulse is generated.
